rv_prefetch_buffer: RTL

- Instruction-side stage between the fetch stage and a pipelined in-order instruction bus.
- Takes fetch's combinational next-PC (im_addr), streams sequential words ahead into a small FIFO, and returns each word one cycle after its address is presented.
- On a non-sequential address it flushes and redirects, discarding responses still in flight.
- im_valid_o has no combinational path from im_addr_i, which breaks fetch's valid→pc_next loop.

---
 rtl/rv_prefetch_buffer_pkg.sv | 17 +
 rtl/rv_prefetch_fifo.sv | 53 +++++
 rtl/rv_prefetch_buffer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rv_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer (carries the rv_defines values).
// No logic, so no latency or backpressure of its own.
package rv_prefetch_buffer_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;

   typedef logic [XLEN-1:0] word_t;

   localparam word_t WORD_STEP = 32'd4;

   // Sequential successor; 32-bit modulo so 0xFFFF_FFFC is followed by 0.
   function automatic word_t next_word(input word_t addr);
      return addr + WORD_STEP;
   endfunction

endpackage

// File: rtl/rv_prefetch_fifo.sv
// DEPTH x XLEN word queue with push/pop/flush; head readable combinationally, writes visible next cycle.
// No backpressure: the parent never pushes into a full queue, which the assertion guards.
module rv_prefetch_fifo
   import rv_prefetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  word_t         wdata,
   output word_t         rdata,
   output logic [CW-1:0] count
);

   word_t         storage [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   assign rdata = storage[rd_ptr];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            storage[i] <= '0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            storage[wr_ptr] <= wdata;
            wr_ptr          <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   a_no_push_when_full : assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && !flush && (count == CW'(DEPTH))));

endmodule

// File: rtl/rv_prefetch_buffer.sv
// Prefetches sequential words ahead of fetch; a word comes back the cycle after its address, one/cycle when warm.
// Bus requests stop while queued + in-flight words reach DEPTH; stale responses after a redirect are dropped.
module rv_prefetch_buffer
   import rv_prefetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter word_t       RESET_ADDR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] im_addr_i,
   output logic [31:0] im_data_o,
   output logic        im_valid_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_rvalid_i
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   typedef logic [CW-1:0] cnt_t;

   word_t       last_addr;
   word_t       head_addr;
   word_t       issue_addr;
   cnt_t        fifo_count;
   cnt_t        inflight;
   cnt_t        drop;
   logic        req_q;

   logic        grant;
   logic        pop_hit;
   logic        redirect;
   logic        push;
   logic        pop;
   word_t       expected_addr;
   cnt_t        inflight_nxt;
   cnt_t        drop_nxt;
   cnt_t        count_nxt;
   logic [CW:0] occupancy_nxt;

   // Valid is a pure register function, so fetch's pc_next mux never loops back into it.
   assign im_valid_o    = (fifo_count != '0) && (head_addr == last_addr);
   assign mem_req_o     = req_q;
   assign mem_addr_o    = issue_addr;

   assign grant         = req_q && mem_gnt_i;
   assign pop_hit       = im_valid_o && (im_addr_i == next_word(last_addr));
   assign expected_addr = pop_hit ? next_word(head_addr) : head_addr;
   assign redirect      = (im_addr_i != expected_addr);
   assign push          = mem_rvalid_i && (drop == '0) && !redirect;
   assign pop           = pop_hit && !redirect;

   always_comb begin
      inflight_nxt = inflight + cnt_t'(grant) - cnt_t'(mem_rvalid_i);

      // A redirect marks everything still outstanding, including this cycle's grant, as stale.
      if (redirect) begin
         drop_nxt = inflight_nxt;
      end else begin
         drop_nxt = drop - cnt_t'(mem_rvalid_i && (drop != '0));
      end

      if (redirect) begin
         count_nxt = '0;
      end else begin
         count_nxt = fifo_count + cnt_t'(push) - cnt_t'(pop);
      end

      occupancy_nxt = {1'b0, count_nxt} + {1'b0, inflight_nxt};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_addr  <= RESET_ADDR;
         head_addr  <= RESET_ADDR;
         issue_addr <= RESET_ADDR;
         inflight   <= '0;
         drop       <= '0;
         req_q      <= 1'b0;
      end else begin
         last_addr <= im_addr_i;
         inflight  <= inflight_nxt;
         drop      <= drop_nxt;
         // Registered so it equals (count + inflight) < DEPTH of the state it is presented with.
         req_q     <= (occupancy_nxt < DEPTH_W);
         if (redirect) begin
            head_addr  <= im_addr_i;
            issue_addr <= im_addr_i;
         end else begin
            if (pop) begin
               head_addr <= next_word(head_addr);
            end
            if (grant) begin
               issue_addr <= next_word(issue_addr);
            end
         end
      end
   end

   rv_prefetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .flush (redirect),
      .push  (push),
      .pop   (pop),
      .wdata (mem_rdata_i),
      .rdata (im_data_o),
      .count (fifo_count)
   );

   a_no_orphan_response : assert property (@(posedge clk_i) disable iff (rst_i)
      !(mem_rvalid_i && (inflight == '0)));

endmodule
